// File: rtl/game_sequencer_if.sv
// Board/print-block bundle for the calculator-game sequencer.
// The master side is the sequencer; the slave side is the board and print block.
interface game_sequencer_if;
    logic       startgame;
    logic [2:0] level_sel;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] value;
    logic       print_done;
    logic [3:0] state;
    logic [2:0] start_level;
    logic [2:0] current_level;
    logic [3:0] response;
    logic [1:0] score;
    logic       game_over;

    modport master (
        input  startgame, level_sel, key_valid, key_code, value, print_done,
        output state, start_level, current_level, response, score, game_over
    );

    modport slave (
        output startgame, level_sel, key_valid, key_code, value, print_done,
        input  state, start_level, current_level, response, score, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Calculator-game controller: levels, keypad answers, score, print handshake.
// Optional answer timeout is enabled by defining GAME_TIMEOUT_EN.
module game_sequencer #(
    parameter int ERR_TICKS      = 4,
    parameter int ANSWER_TIMEOUT = 15,
    parameter int LAST_LEVEL     = 3
) (
    input  logic tick,
    input  logic reset,
    game_sequencer_if.master bus
);
    localparam int CMAX = (ERR_TICKS > ANSWER_TIMEOUT) ? ERR_TICKS : ANSWER_TIMEOUT;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [2:0]    LAST   = 3'(LAST_LEVEL);
    localparam logic [CW-1:0] ERR_LD = CW'(ERR_TICKS - 1);
    localparam logic [3:0]    R_NONE = 4'd11;

    // Encodings double as display codes; HOLD is shown as 0.
    typedef enum logic [3:0] {
        S_GAP   = 4'd0,
        S_TITLE = 4'd1,
        S_CLEAR = 4'd2,
        S_QUEST = 4'd3,
        S_ANS   = 4'd4,
        S_SCORE = 4'd8,
        S_BYE   = 4'd10,
        S_ERR   = 4'd11,
        S_HOLD  = 4'd15
    } st_t;

    st_t           r_st, w_st, r_tgt, w_tgt;
    logic [3:0]    r_disp;
    logic [2:0]    r_sl, w_sl, r_cl, w_cl, w_clamp;
    logic [3:0]    r_resp, w_resp;
    logic [1:0]    r_score, w_score;
    logic          r_over, w_over;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          w_digit, w_submit, w_advance;

    always_comb begin
        w_clamp = bus.level_sel;
        if (bus.level_sel == 3'd0)
            w_clamp = 3'd1;
        else if (bus.level_sel > LAST)
            w_clamp = LAST;
    end

    assign w_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    assign w_submit = bus.key_valid && (bus.key_code == 4'd14) && (r_resp != R_NONE);

    always_comb begin
        w_st      = r_st;
        w_tgt     = r_tgt;
        w_sl      = r_sl;
        w_cl      = r_cl;
        w_resp    = r_resp;
        w_score   = r_score;
        w_over    = r_over;
        w_cnt     = r_cnt;
        w_advance = 1'b0;
        unique case (r_st)
            S_GAP: begin
                w_st = r_tgt;
                if (r_tgt == S_ANS) begin
                    w_resp = R_NONE;
`ifdef GAME_TIMEOUT_EN
                    w_cnt = CW'(ANSWER_TIMEOUT);
`endif
                end
            end
            S_TITLE: begin
                w_sl = w_clamp;
                if (bus.print_done) begin
                    w_cl    = w_clamp;
                    w_score = 2'd0;
                    w_st    = S_GAP;
                    w_tgt   = S_CLEAR;
                end
            end
            S_CLEAR: w_st = S_QUEST;
            S_QUEST: begin
                if (bus.print_done) begin
                    w_st  = S_GAP;
                    w_tgt = S_ANS;
                end
            end
            S_ANS: begin
                if (w_digit) begin
                    w_resp = bus.key_code;
                end else if (w_submit) begin
                    if (r_resp == bus.value) begin
                        if (r_score != 2'd3)
                            w_score = r_score + 2'd1;
                        w_advance = 1'b1;
                    end else begin
                        w_st  = S_ERR;
                        w_cnt = ERR_LD;
                    end
                end
`ifdef GAME_TIMEOUT_EN
                // A digit keeps counting down; only a submit escapes.
                if (w_st == S_ANS && !w_advance) begin
                    if (r_cnt <= CW'(1)) begin
                        w_st  = S_ERR;
                        w_cnt = ERR_LD;
                    end else begin
                        w_cnt = r_cnt - CW'(1);
                    end
                end
`endif
            end
            S_ERR: begin
                if (r_cnt == '0)
                    w_advance = 1'b1;
                else
                    w_cnt = r_cnt - CW'(1);
            end
            S_SCORE: begin
                if (bus.print_done) begin
                    w_st  = S_GAP;
                    w_tgt = S_BYE;
                end
            end
            S_BYE: begin
                if (bus.print_done) begin
                    w_st   = S_HOLD;
                    w_over = 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus.startgame) begin
                    w_st   = S_TITLE;
                    w_over = 1'b0;
                end
            end
            default: w_st = S_GAP;
        endcase
        if (w_advance) begin
            w_st = S_GAP;
            if (r_cl == LAST) begin
                w_tgt = S_SCORE;
            end else begin
                w_cl  = r_cl + 3'd1;
                w_tgt = S_CLEAR;
            end
        end
    end

    always_ff @(posedge tick or posedge reset) begin
        if (reset) begin
            r_st    <= S_GAP;
            r_tgt   <= S_TITLE;
            r_disp  <= 4'd0;
            r_sl    <= 3'd1;
            r_cl    <= 3'd1;
            r_resp  <= R_NONE;
            r_score <= 2'd0;
            r_over  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_st    <= w_st;
            r_tgt   <= w_tgt;
            r_disp  <= (w_st == S_HOLD) ? 4'd0 : w_st;
            r_sl    <= w_sl;
            r_cl    <= w_cl;
            r_resp  <= w_resp;
            r_score <= w_score;
            r_over  <= w_over;
            r_cnt   <= w_cnt;
        end
    end

    assign bus.state         = r_disp;
    assign bus.start_level   = r_sl;
    assign bus.current_level = r_cl;
    assign bus.response      = r_resp;
    assign bus.score         = r_score;
    assign bus.game_over     = r_over;
endmodule

// File: doc/game_sequencer.md
# game_sequencer

- Top-level game controller for the calculator game.
- Generates the 4-bit display `state` code consumed by the seven-segment print block, and handshakes with it on `print_done`.
- Tracks level, player response and score.
- Sits between the board inputs (start switch, level switches, keypad) and the print block, and takes the expected answer `value` back from it.

## Interface
Parameters:
- `ERR_TICKS`, default 4: ticks the error screen (dashes) is held after a wrong or timed-out answer.
- `ANSWER_TIMEOUT`, default 15: ticks allowed in the answer state before forced failure (only with `GAME_TIMEOUT_EN`).
- `LAST_LEVEL`, default 3: final level number.

Ports:
- `tick` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `startgame` in 1: start switch (level).
- `level_sel` in 3: requested start level.
- `key_valid` in 1: one-tick keypad strobe.
- `key_code` in 4: key value; 0–9 digit, 14 enter, others ignored.
- `value` in 4: expected answer reported by print block.
- `print_done` in 1: print block completion flag.
- `state` out 4: display code: 0 gap, 1 title, 2 clear, 3 question, 4 answer, 8 score, 10 bye, 11 error.
- `start_level` out 3: clamped start level.
- `current_level` out 3: level being played.
- `response` out 4: entered digit, 11 = none (shown as dash).
- `score` out 2: correct answers, saturating.
- `game_over` out 1: high in HOLD after bye screen.

## Operation
- All outputs registered.
- Reset values: `state`=0, `start_level`=1, `current_level`=1, `response`=11, `score`=0, `game_over`=0. Internal FSM goes to GAP with next-target TITLE.
- GAP (`state`=0) lasts exactly one tick between any two handshake states. This lets the print block clear `print_done` and reload its delay. `print_done` is never sampled in GAP.
- TITLE (1):
  - `start_level` = `level_sel` clamped: 0→1, >`LAST_LEVEL`→`LAST_LEVEL`.
  - On `print_done`: `current_level`←`start_level`, `score`←0, go GAP→CLEAR.
- CLEAR (2): held one tick, then QUESTION. No handshake.
- QUESTION (3): wait `print_done`, then GAP→ANSWER.
- ANSWER (4):
  - On entry: `response`←11 and timeout counter loaded.
  - `key_valid` with digit: `response`←digit, overwriting any earlier digit.
  - `key_valid` with 14 while `response`≠11: submit.
  - Enter with `response`=11 is ignored.
  - Correct submit (`response`==`value`): `score`←min(`score`+1, 3), then advance.
  - Wrong submit: go ERROR.
- ERROR (11): held `ERR_TICKS` ticks, then advance.
- Advance: if `current_level`==`LAST_LEVEL`, go GAP→SCORE. Otherwise `current_level`+1, then GAP→CLEAR.
- SCORE (8): wait `print_done`, then GAP→BYE.
- BYE (10): wait `print_done`, then go to HOLD.
- HOLD (`state`=0, `game_over`=1): wait until `startgame`=0, then go TITLE with `game_over`←0. This stops a still-held start switch from restarting the game immediately.
- A digit and an enter in the same tick is impossible (single `key_code`). A `key_valid` outside ANSWER is ignored.

## Timing
- Each handshake state exits on the first tick edge where `print_done`=1, then inserts exactly one GAP tick.
- Answer check uses `value` and `response` as registered at the enter tick. The score update is visible on the next edge, coincident with leaving ANSWER.
- Question-to-question latency with no waits: ANSWER exit → GAP (1) → CLEAR (1) → QUESTION.
- Asynchronous `reset` mid-game returns all outputs to reset values immediately, regardless of state.

## Configuration
- `GAME_TIMEOUT_EN` defined:
  - The ANSWER counter loads `ANSWER_TIMEOUT` and decrements each tick.
  - Reaching 0 with no submit goes to ERROR, exactly as a wrong answer.
  - A digit key does not reload the counter.
- Undefined: no counter logic; ANSWER waits indefinitely for a submit.

## Test plan
- Reset during ANSWER at level 2 with score 1 → next tick `state`=0, `score`=0, `current_level`=1, `response`=11; GAP then TITLE.
- `level_sel`=5 in TITLE, `print_done` pulse → `start_level`=3; after CLEAR→QUESTION, `current_level`=3.
- Level 1, `value`=3: keys 7, 3, enter → `response`=3, `score` 0→1, sequence GAP(0), CLEAR(2), QUESTION(3) at level 2.
- Wrong answer 5 vs `value`=6 → `state`=11 for exactly 4 ticks, `score` unchanged, then advance. Enter with no digit → stays in ANSWER.
- Three correct answers starting at level 1 → `score`=3, then SCORE(8), BYE(10), HOLD with `game_over`=1. With `startgame` held high it stays in HOLD; dropping it → TITLE.
- With `GAME_TIMEOUT_EN` and no keys → ERROR entered 15 ticks after ANSWER entry. Without the macro → still in ANSWER after 100 ticks.
